// File: rtl/dma_write_burst_engine.sv
// dma_write_burst_engine: drains a show-ahead FIFO to AXI4 as 4 KB-safe INCR bursts with bounded outstanding writes
module dma_write_burst_engine #(
    parameter int DATA_W          = 512,
    parameter int ADDR_W          = 64,
    parameter int LEN_W           = 32,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                desc_valid,
    output logic                desc_ready,
    input  logic [ADDR_W-1:0]   desc_addr,
    input  logic [LEN_W-1:0]    desc_len,
    input  logic                abort,
    input  logic                err_clear,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err,
    output logic [1:0]          err_resp,
    output logic [LEN_W-1:0]    beats_done,
    input  logic                fifo_valid,
    input  logic [DATA_W-1:0]   fifo_data,
    output logic                fifo_ready,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);
    localparam int SZ = $clog2(DATA_W / 8);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [12:0] MB = 13'(MAX_BURST);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERROR} state_t;
    state_t state, state_n;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     q_cnt;
    logic [8:0]        q_mem [MAX_OUTSTANDING];
    logic [PW-1:0]     q_wr, q_rd;
    logic              w_active;
    logic [8:0]        w_left;
    logic              abort_seen;
    logic [12:0]       room, cap, blen;
    logic              aw_fire, w_fire, b_fire, pop, issue, done_n;

    assign desc_ready = state == IDLE;
    assign busy       = state != IDLE;
    assign awsize     = 3'(SZ);
    assign awburst    = 2'b01;
    assign wvalid     = w_active & fifo_valid;
    assign fifo_ready = wvalid & wready;
    assign wdata      = fifo_data;
    assign wstrb      = '1;
    assign wlast      = w_left == 9'd1;
    assign bready     = outstanding != '0;
    assign aw_fire    = awvalid & awready;
    assign w_fire     = wvalid & wready;
    assign b_fire     = bvalid & bready;
    // Beats left before the next 4 KB page, capped by MAX_BURST and what remains.
    assign room  = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;
    assign cap   = room < MB ? room : MB;
    assign blen  = remaining < LEN_W'(cap) ? 13'(remaining) : cap;
    assign issue = state == RUN && !awvalid && remaining != '0 &&
                   outstanding < OW'(MAX_OUTSTANDING) && !abort && !err;
    assign pop   = (!w_active || (w_fire && wlast)) && q_cnt != '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (desc_valid) state_n = desc_len == '0 ? DONE : RUN;
            RUN:     if (remaining == '0 || abort || err) state_n = DRAIN;
            DRAIN:   if (!awvalid && outstanding == '0) state_n = err ? ERROR : DONE;
            DONE:    state_n = IDLE;
            ERROR:   if (err_clear) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        done_n = state == DONE || (state != ERROR && state_n == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
            q_cnt       <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            w_active    <= 1'b0;
            w_left      <= '0;
            abort_seen  <= 1'b0;
            awvalid     <= 1'b0;
            awaddr      <= '0;
            awlen       <= '0;
            beats_done  <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            err         <= 1'b0;
            err_resp    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && desc_valid) begin
                addr       <= desc_addr;
                remaining  <= desc_len;
                beats_done <= '0;
                abort_seen <= 1'b0;
            end else if (w_fire)
                beats_done <= beats_done + 1'b1;
            if (issue) begin
                awvalid   <= 1'b1;
                awaddr    <= addr;
                awlen     <= 8'(blen - 13'd1);
                addr      <= addr + (ADDR_W'(blen) << SZ);
                remaining <= remaining - LEN_W'(blen);
            end else if (aw_fire)
                awvalid <= 1'b0;
            if (state == RUN && abort && remaining != '0) abort_seen <= 1'b1;
            outstanding <= outstanding + OW'(aw_fire) - OW'(b_fire);
            q_cnt       <= q_cnt + OW'(aw_fire) - OW'(pop);
            q_wr        <= !aw_fire ? q_wr : q_wr == PW'(MAX_OUTSTANDING - 1) ? '0 : q_wr + 1'b1;
            q_rd        <= !pop ? q_rd : q_rd == PW'(MAX_OUTSTANDING - 1) ? '0 : q_rd + 1'b1;
            w_active    <= pop || (w_active && !(w_fire && wlast));
            w_left      <= pop ? q_mem[q_rd] : w_left - 9'(w_fire);
            done        <= done_n;
            aborted     <= done_n && abort_seen;
            if (err_clear) begin
                err      <= 1'b0;
                err_resp <= '0;
            end else if (b_fire && bresp != 2'b00) begin
                err <= 1'b1;
                if (!err) err_resp <= bresp;
            end
        end
    end

    always_ff @(posedge clk)
        if (aw_fire) q_mem[q_wr] <= 9'(awlen) + 9'd1;
endmodule

// File: tb/tb_dma_write_burst_engine.sv
// tb_dma_write_burst_engine: vector table plus corner sequences, AW/W/data scoreboard against a burst-split model
module tb_dma_write_burst_engine;
    logic         clk = 1'b0, reset = 1'b1;
    logic         desc_valid = 1'b0, desc_ready, abort = 1'b0, err_clear = 1'b0;
    logic [63:0]  desc_addr = '0;
    logic [31:0]  desc_len = '0, beats_done;
    logic         busy, done, aborted, err;
    logic [1:0]   err_resp, awburst, bresp;
    logic         fifo_valid, fifo_ready, awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [511:0] fifo_data, wdata;
    logic [63:0]  awaddr, wstrb;
    logic [7:0]   awlen;
    logic [2:0]   awsize;

    always #5 clk = ~clk;

    dma_write_burst_engine dut (
        .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len), .abort(abort), .err_clear(err_clear),
        .busy(busy), .done(done), .aborted(aborted), .err(err), .err_resp(err_resp),
        .beats_done(beats_done), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_ready(fifo_ready), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .bresp(bresp)
    );

    typedef struct { logic [63:0] addr; int len; bit rnd; int aws; } vec_t;
    typedef struct { logic [63:0] addr; int len; } aw_t;

    aw_t         aw_exp[$];
    int          wlen_q[$];
    logic [31:0] dq[$];
    int          total = 0, bad = 0;
    int          aw_cnt = 0, b_cnt = 0, b_pend = 0, cur_left = 0;
    int          aw_limit = 1 << 30, b_err_at = 0;
    bit          rnd = 0, fifo_adv = 0, b_hs = 0;
    logic [31:0] fifo_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference split: 64 beats of 64 bytes max, never past a 4 KB page.
    function automatic int plan(input logic [63:0] a, input int len);
        int n = 0;
        int rem = len;
        logic [63:0] p = a;
        while (rem > 0) begin
            int room = (4096 - int'(p % 4096)) / 64;
            int b = rem < 64 ? rem : 64;
            if (room < b) b = room;
            aw_exp.push_back('{p, b});
            p += 64'(b) * 64;
            rem -= b;
            n++;
        end
        return n;
    endfunction

    task automatic flush();
        aw_exp.delete();
        wlen_q.delete();
        dq.delete();
        dq.push_back(fifo_word);
        aw_cnt = 0;
        b_cnt = 0;
        cur_left = 0;
    endtask

    task automatic check_aw();
        aw_t e;
        aw_cnt++;
        chk("outstanding_le_8", (aw_cnt - b_cnt) <= 8, 1);
        chk("aw_expected", aw_exp.size() != 0, 1);
        if (aw_exp.size() != 0) begin
            e = aw_exp.pop_front();
            chk("awaddr", awaddr, e.addr);
            chk("awlen", awlen, 64'(e.len - 1));
            chk("awsize", awsize, 6);
            chk("awburst", awburst, 1);
            wlen_q.push_back(e.len);
        end
    endtask

    task automatic check_w();
        logic [31:0] e;
        if (cur_left == 0) begin
            chk("w_after_aw", wlen_q.size() != 0, 1);
            if (wlen_q.size() != 0) cur_left = wlen_q.pop_front();
        end
        chk("wlast", wlast, cur_left == 1);
        chk("wstrb", wstrb, {64{1'b1}});
        chk("wdata_avail", dq.size() != 0, 1);
        if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("wdata_lo", wdata[31:0], e);
            chk("wdata_hi", wdata[511:480], e);
        end
        if (cur_left > 0) cur_left--;
    endtask

    // Slave/FIFO model: drive on the falling edge, sample handshakes 1 ns later.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; fifo_valid = 0;
        fifo_word = $urandom;
        fifo_data = {16{fifo_word}};
        forever begin
            @(negedge clk);
            if (reset) begin
                awready = 0; wready = 0; bvalid = 0; fifo_valid = 0;
                b_pend = 0; fifo_adv = 0; b_hs = 0;
                continue;
            end
            if (fifo_adv) begin
                fifo_word = $urandom;
                fifo_data = {16{fifo_word}};
                dq.push_back(fifo_word);
            end
            if (b_hs) bvalid = 0;
            awready    = (aw_cnt < aw_limit) && (!rnd || $urandom_range(0, 1) == 1);
            wready     = !rnd || $urandom_range(0, 3) != 0;
            fifo_valid = !rnd || $urandom_range(0, 3) != 0;
            if (!bvalid && b_pend > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
                bvalid = 1;
                bresp  = (b_cnt + 1 == b_err_at) ? 2'b10 : 2'b00;
            end
            #1;
            fifo_adv = fifo_valid && fifo_ready;
            b_hs     = bvalid && bready;
            if (wvalid && wready) begin
                if (wlast) b_pend++;
                check_w();
            end
            if (awvalid && awready) check_aw();
            if (b_hs) begin
                b_cnt++;
                b_pend--;
            end
        end
    end

    task automatic start(input logic [63:0] a, input int len, input bit r, output int n);
        flush();
        rnd = r;
        n = plan(a, len);
        @(negedge clk);
        desc_valid = 1; desc_addr = a; desc_len = 32'(len);
        #1 chk("desc_ready", desc_ready, 1);
        @(negedge clk);
        desc_valid = 0;
    endtask

    task automatic wait_done(input int budget, output bit ab);
        bit seen = 0;
        ab = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                ab = aborted;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit ab;
        start(v.addr, v.len, v.rnd, n);
        wait_done(20000, ab);
        chk("aborted", ab, 0);
        chk("aw_count", aw_cnt, v.aws);
        chk("beats_done", beats_done, v.len);
        chk("aw_left", aw_exp.size(), 0);
        chk("err", err, 0);
        @(negedge clk);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   n;
        bit   ab, seen;
        vecs[0] = '{64'h0, 4, 1'b0, 1};
        vecs[1] = '{64'hF80, 8, 1'b0, 2};
        vecs[2] = '{64'h0, 1000, 1'b1, 16};
        vecs[3] = '{64'hFC0, 3, 1'b1, 2};
        vecs[4] = '{64'h40, 130, 1'b0, 3};
        vecs[5] = '{64'h1_0000_0FC0, 65, 1'b1, 2};

        repeat (3) @(negedge clk);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err", err, 0);
        chk("rst_err_resp", err_resp, 0);
        chk("rst_beats", beats_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_desc_ready", desc_ready, 1);
        reset = 0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // zero-length descriptor
        flush();
        rnd = 0;
        @(negedge clk);
        desc_valid = 1; desc_addr = 64'h100; desc_len = 0;
        @(negedge clk);
        desc_valid = 0;
        chk("len0_done_c1", done, 0);
        chk("len0_awvalid", awvalid, 0);
        @(negedge clk);
        chk("len0_done_c2", done, 1);
        chk("len0_aborted", aborted, 0);
        @(negedge clk);
        chk("len0_done_off", done, 0);
        chk("len0_no_aw", aw_cnt, 0);

        // SLVERR on the second B with a third AW already waiting
        aw_limit = 2;
        b_err_at = 2;
        start(64'h0, 256, 0, n);
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (err) seen = 1;
        end
        chk("err_seen", seen, 1);
        chk("err_resp_early", err_resp, 2);
        chk("err_aw_held", awvalid, 1);
        chk("err_aw_count", aw_cnt, 2);
        aw_limit = 1 << 30;
        wait_done(3000, ab);
        chk("err_busy", busy, 1);
        chk("err_sticky", err, 1);
        chk("err_resp", err_resp, 2);
        chk("err_aws", aw_cnt, 3);
        chk("err_beats", beats_done, 192);
        repeat (5) @(negedge clk);
        chk("err_hold", busy, 1);
        chk("err_no_aw", awvalid, 0);
        err_clear = 1;
        @(negedge clk);
        err_clear = 0;
        chk("err_cleared", err, 0);
        chk("err_resp_cleared", err_resp, 0);
        chk("err_idle", busy, 0);
        b_err_at = 0;

        // abort in IDLE is ignored
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_idle", busy, 0);
        run_vec(vecs[0]);

        // abort right after the second AW handshake
        start(64'h0, 512, 0, n);
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (aw_cnt >= 2) seen = 1;
        end
        abort = 1;
        chk("abort_aw2_seen", seen, 1);
        repeat (3) @(negedge clk);
        abort = 0;
        wait_done(3000, ab);
        chk("abort_flag", ab, 1);
        chk("abort_aws", aw_cnt, 2);
        chk("abort_beats", beats_done, 128);

        // reset mid-burst
        start(64'h0, 1000, 0, n);
        repeat (100) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_fifo_ready", fifo_ready, 0);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_beats", beats_done, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
